pc_unit: RTL
============

Name: pc_unit

Overview:
Parametrised program-counter unit, the successor to the fixed 16-bit PC register. It holds the fetch address and selects the next PC from sequential, branch, jump, call and return sources. It adds a stall enable, a configurable reset vector and step, and a small circular return-address stack (RAS) for call/return. It sits at the head of the fetch stage, feeding instruction memory and the PC+step adder path.

Parameters:
WIDTH, 16, PC width in bits.
RESET_VECTOR, 16'h0000, PC value loaded on reset (WIDTH bits).
STEP, 2, increment applied for sequential fetch and call return address.
RAS_DEPTH, 4, return-address stack entries; must be a power of two, at least 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  1 = PC may update this cycle; 0 = stall (hold all state)
branch_taken  input  1  take branch_target
branch_target  input  WIDTH  branch destination
jump  input  1  take jump_target
call  input  1  jump to jump_target and push return address
jump_target  input  WIDTH  jump/call destination
ret  input  1  pop RAS top into PC
pc_out  output  WIDTH  current PC (registered)
pc_plus  output  WIDTH  pc_out + STEP (combinational)
ras_empty  output  1  RAS holds 0 entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_overflow  output  1  sticky: a call was made while full
ras_underflow  output  1  sticky: a ret was made while empty

Behaviour:
- All state updates on the rising clk edge; the effect of a control input appears on pc_out exactly 1 cycle later.
- Reset (rst=1 at the edge) overrides everything:
  - pc_out=RESET_VECTOR; RAS count=0, top pointer=0, entries don't-care.
  - Outputs: ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0.
- Stall: en=0 and rst=0 -> pc_out, RAS contents, pointers and flags all hold; control inputs are ignored.
- Next-PC priority when en=1 (first match wins):
  1. ret
  2. call
  3. jump
  4. branch_taken
  5. sequential (pc_plus)
- Only the winning source acts. A lower-priority request asserted in the same cycle is dropped, with no side effect and no push.
- ret, RAS non-empty: pc_out <= entry at top; count decrements.
- ret, RAS empty: pc_out <= pc_plus; ras_underflow <= 1; count stays 0.
- call: pc_out <= jump_target; push pc_plus.
  - Not full: count increments.
  - Full: the push overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_overflow <= 1.
- jump: pc_out <= jump_target. branch_taken: pc_out <= branch_target. No RAS change for either.
- Arithmetic: pc_plus = (pc_out + STEP) mod 2^WIDTH. The PC wraps silently, with no flag.
- Sticky flags clear only on rst.
- ras_empty and ras_full are derived from the registered count, so they update in the same cycle as pc_out.
- RAS storage uses a top pointer in log2(RAS_DEPTH) bits, modulo RAS_DEPTH:
  - push writes at top+1 and advances the pointer;
  - pop reads at top and retreats the pointer.

Test Plan:
- Reset then sequential: rst for 1 cycle, en=1, no controls -> pc_out = 0x0000, 0x0002, 0x0004, 0x0006 on successive cycles; ras_empty=1.
- Stall and priority: at pc=0x0010, en=0 with jump=1 for 2 cycles -> pc holds 0x0010. Then en=1 with jump=1 (target 0x0100) and branch_taken=1 (target 0x0200) in the same cycle -> pc=0x0100.
- Call/return nesting: call to 0x0040 at pc=0x0010, then call to 0x0080 at pc=0x0040, then ret, ret -> pc sequence 0x0040, 0x0080, 0x0042, 0x0012; ras_empty returns to 1.
- RAS overflow: 5 calls (RAS_DEPTH=4) from pcs 0x0000, 0x0010, 0x0020, 0x0030, 0x0040 -> ras_full=1, ras_overflow=1. Then 4 rets pop 0x0042, 0x0032, 0x0022, 0x0012; the first return address, 0x0002, is lost.
- Underflow: ret with RAS empty at pc=0x0020 -> pc=0x0022, ras_underflow=1 and still set 10 cycles later; rst clears it.
- Wrap and reset mid-operation: RESET_VECTOR=0xFFFC -> pc = 0xFFFC, 0xFFFE, 0x0000. With 2 RAS entries live, assert rst together with call=1 -> pc=0xFFFC, ras_empty=1, no push.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address and selects the next PC from the
// sequential, branch, jump, call and return sources. Includes a circular return-address stack.
module pc_unit #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      STEP         = 2,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int unsigned      PW       = $clog2(RAS_DEPTH);
    localparam int unsigned      CW       = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] StepInc  = WIDTH'(STEP);
    localparam logic [CW-1:0]    CountMax = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    assign pc_plus       = pc_q + StepInc;
    assign pc_out        = pc_q;
    assign ras_empty     = (count_q == '0);
    assign ras_full      = (count_q == CountMax);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

    always_comb begin
        pc_d    = pc_q;
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (en) begin
            if (ret) begin
                if (!ras_empty) begin
                    pc_d    = ras_q[top_q];
                    top_d   = top_q - PW'(1);
                    count_d = count_q - CW'(1);
                end else begin
                    pc_d  = pc_plus;
                    unf_d = 1'b1;
                end
            end else if (call) begin
                pc_d  = jump_target;
                push  = 1'b1;
                top_d = top_q + PW'(1);
                // When full the pointer wraps onto the oldest entry, which is overwritten.
                if (ras_full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end else if (jump) begin
                pc_d = jump_target;
            end else if (branch_taken) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries need no reset; the count decides which are valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_q[top_d] <= pc_plus;
        end
    end

endmodule
